// File: rtl/g2b_pkg.sv
// Shared types for the bit-serial Gray-to-binary decoder.
// State codes, state width and counter-width helper.
package g2b_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MSB  = 3'd2,
    S_XOR  = 3'd3,
    S_DEC  = 3'd4,
    S_DONE = 3'd5
  } g2b_state_e;

  // Counter must hold WIDTH-2; never narrower than one bit.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gray_to_bin_serial_if.sv
// Request/result bundle for gray_to_bin_serial.
// master: start, gray_in out; bin_out, busy, done in. slave: reverse.
interface gray_to_bin_serial_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output gray_in,
    input  bin_out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  gray_in,
    output bin_out,
    output busy,
    output done
  );

endinterface

// File: rtl/g2b_control.sv
// Control FSM of the serial Gray-to-binary decoder.
// In: clk, reset, start, cnt_zero. Out: datapath strobes, busy, done.
// G2B_FAST_EN folds the decrement into the XOR state.
module g2b_control
  import g2b_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic cnt_zero,
  output logic r1_in,
  output logic r2_in,
  output logic msb_copy,
  output logic cnt_load,
  output logic cnt_dec,
  output logic busy,
  output logic done
);

  g2b_state_e state_q;
  g2b_state_e state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    r1_in    = 1'b0;
    r2_in    = 1'b0;
    msb_copy = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE) &&
               (state_q != S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        r1_in    = 1'b1;
        cnt_load = 1'b1;
        state_d  = S_MSB;
      end
      S_MSB: begin
        msb_copy = 1'b1;
        state_d  = S_XOR;
      end
`ifdef G2B_FAST_EN
      S_XOR: begin
        r2_in = 1'b1;
        if (cnt_zero) begin
          state_d = S_DONE;
        end else begin
          cnt_dec = 1'b1;
          state_d = S_XOR;
        end
      end
`else
      S_XOR: begin
        r2_in   = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (cnt_zero) begin
          state_d = S_DONE;
        end else begin
          cnt_dec = 1'b1;
          state_d = S_XOR;
        end
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (!start) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/gray_to_bin_serial.sv
// Bit-serial Gray-to-binary decoder: R1 holds Gray word, R2 result.
// Ports: clk, reset, bus (slave). Option macro: G2B_FAST_EN.
module gray_to_bin_serial
  import g2b_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  gray_to_bin_serial_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("gray_to_bin_serial: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] r2_q;
  logic [CW-1:0]    cnt_q;
  logic             cnt_zero;
  logic             r1_in;
  logic             r2_in;
  logic             msb_copy;
  logic             cnt_load;
  logic             cnt_dec;

  assign cnt_zero = (cnt_q == '0);

  g2b_control u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (bus.start),
    .cnt_zero (cnt_zero),
    .r1_in    (r1_in),
    .r2_in    (r2_in),
    .msb_copy (msb_copy),
    .cnt_load (cnt_load),
    .cnt_dec  (cnt_dec),
    .busy     (bus.busy),
    .done     (bus.done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q  <= '0;
      r2_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (r1_in) begin
        r1_q <= bus.gray_in;
        r2_q <= '0;
      end else begin
        if (msb_copy) begin
          r2_q[WIDTH-1] <= r1_q[WIDTH-1];
        end
        // Resolve bit cnt from the already-decoded bit above it.
        if (r2_in) begin
          for (int i = 0; i < WIDTH-1; i++) begin
            if (cnt_q == CW'(i)) begin
              r2_q[i] <= r2_q[i+1] ^ r1_q[i];
            end
          end
        end
      end
      if (cnt_load) begin
        cnt_q <= CW'(WIDTH-2);
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign bus.bin_out = r2_q;

endmodule

// File: tb/tb_gray_to_bin_serial.sv
// Self-checking bench for gray_to_bin_serial (WIDTH=8).
// Reference decode is the XOR of all right shifts of the Gray word.
module tb_gray_to_bin_serial;

  localparam int W = 8;
`ifdef G2B_FAST_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = 2*W + 1;
`endif

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  gray_to_bin_serial_if #(.WIDTH(W)) bus ();

  gray_to_bin_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One conversion: start held until done unless disturb drops it
  // (and scrambles gray_in) after the LOAD cycle.
  task automatic conv(input logic [W-1:0] g, input bit chk_busy,
                      input bit disturb, input int hold);
    int n;
    logic [W-1:0] exp;
    exp = ref_g2b(g);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.gray_in = g;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (disturb && n == 2) begin
        bus.gray_in = 8'h3C;
        bus.start   = 1'b0;
      end
      if (chk_busy && !bus.done) check("busy_run", int'(bus.busy), 1);
    end while (!bus.done && n < 4*W);
    check("latency", n, LAT);
    check("bin_out", int'(bus.bin_out), int'(exp));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_done", int'(bus.done), 1);
      check("hold_bin", int'(bus.bin_out), int'(exp));
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_done", int'(bus.done), 0);
    check("idle_busy", int'(bus.busy), 0);
  endtask

  initial begin
    logic [W-1:0] words [256];
    logic [W-1:0] t;
    int j;
    n_pass      = 0;
    n_total     = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.gray_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_bin", int'(bus.bin_out), 0);
    reset = 1'b0;

    conv(8'hC5, 1'b1, 1'b0, 5);
    check("c5_const", int'(bus.bin_out), 32'h86);
    check("c5_after", int'(bus.bin_out), int'(ref_g2b(8'hC5)));
    conv(8'h80, 1'b0, 1'b0, 0);
    check("80_const", int'(bus.bin_out), 32'hFF);
    conv(8'hFF, 1'b0, 1'b0, 0);
    check("ff_const", int'(bus.bin_out), 32'hAA);
    conv(8'h00, 1'b0, 1'b0, 0);
    check("00_const", int'(bus.bin_out), 32'h00);

    conv(8'hC5, 1'b0, 1'b1, 0);
    check("disturb_const", int'(bus.bin_out), 32'h86);

    // Abort in cycle 8 of a conversion.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.gray_in = 8'hC5;
    @(posedge clk);
    repeat (7) @(negedge clk);
    check("mid_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_bin", int'(bus.bin_out), 0);
    reset     = 1'b0;
    bus.start = 1'b0;
    conv(8'hFF, 1'b0, 1'b0, 0);
    check("post_abort", int'(bus.bin_out), 32'hAA);

    // All 256 words in shuffled order.
    for (int i = 0; i < 256; i++) words[i] = W'(i);
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = words[i];
      words[i] = words[j];
      words[j] = t;
    end
    for (int i = 0; i < 256; i++) conv(words[i], 1'b0, 1'b0, 0);

    for (int i = 0; i < 16; i++)
      conv(W'($urandom), 1'b1, 1'b0, int'($urandom_range(3, 0)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gray_to_bin_serial.md
Name: gray_to_bin_serial

Overview:
- Bit-serial Gray-to-binary decoder. It is the inverse partner of the existing binary-to-Gray converter and is structured the same way: a control FSM plus a register datapath.
- Captures a WIDTH-bit Gray word, copies the MSB, then resolves one bit per iteration, MSB-1 down to bit 0, using b[i] = b[i+1] XOR g[i].
- Used wherever Gray-coded values (counters, encoders) are returned to binary.

Parameters:
- WIDTH, 8, word width in bits. Legal range is WIDTH >= 2; any smaller value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request; sampled only in IDLE and DONE.
- gray_in  in  WIDTH  Gray word; sampled only in the LOAD cycle.
- bin_out  out  WIDTH  registered binary result; valid while done=1.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE only.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). It is sampled only on the clk rising edge.
- Reset values: state=IDLE, R1 (Gray capture)=0, R2/bin_out=0, cnt=0, busy=0, done=0.
- Reset mid-conversion aborts: all registers take their reset values at the next edge, and no partial result is retained.
- States, 3-bit encoding: IDLE=0, LOAD=1, MSB=2, XOR=3, DEC=4, DONE=5. Codes 6 and 7 return to IDLE.
- IDLE: start=1 -> LOAD; otherwise stay.
- LOAD: R1<=gray_in; R2<=0; cnt<=WIDTH-2. Next state is MSB.
- MSB: R2[WIDTH-1]<=R1[WIDTH-1]. Next state is XOR.
- XOR: R2[cnt]<=R2[cnt+1]^R1[cnt]. Next state is DEC.
- DEC: if cnt==0 -> DONE; else cnt<=cnt-1 -> XOR.
- DONE: done=1. Stay while start=1; start=0 -> IDLE next cycle. bin_out holds its value until the next LOAD.
- start changes during LOAD through DEC are ignored; the conversion always completes.
- Latency: done rises 2*WIDTH+1 cycles after the edge that samples start=1 in IDLE (17 cycles for WIDTH=8).
- Back-to-back conversions need start to drop for at least one cycle. The minimum period is 2*WIDTH+3 cycles.
- cnt width is clog2(WIDTH); it never wraps, because DEC exits at 0.
- bin_out is a direct register output, with no combinational path from gray_in.

Optional Feature:
- Macro G2B_FAST_EN.
- Defined: XOR and DEC merge into a single XOR state that writes the bit and decrements (or exits to DONE when cnt==0) in the same cycle. Latency becomes WIDTH+2 (10 cycles for WIDTH=8). The DEC encoding is unused and returns to IDLE.
- Undefined: the two-cycle-per-bit schedule above applies.
- Result values are identical in both builds.

Decomposition:
- Package g2b_pkg holds:
  - the state encodings as localparams/typedef (IDLE..DONE);
  - a STATE_W=3 constant;
  - a clog2-based CNT_W function.
- Natural split: sub-module g2b_control contains the FSM only. It takes cnt_zero as input and drives r1_in, r2_in, msb_copy, cnt_load, cnt_dec, busy and done.
- The top level holds R1, R2 and the counter.

Test Plan:
- Reset, then gray_in=8'hC5 with a start pulse held to DONE -> done at cycle 17 (10 with G2B_FAST_EN), bin_out=8'h86, busy=1 from cycles 1-16.
- gray_in=8'h80 -> bin_out=8'hFF; gray_in=8'hFF -> 8'hAA; gray_in=8'h00 -> 8'h00.
- start held high through DONE for 5 cycles -> done stays 1, bin_out stable. start low -> IDLE next cycle, done=0.
- gray_in changed from 8'hC5 to 8'h3C one cycle after LOAD, and start dropped mid-run -> result is still 8'h86 and the conversion completes.
- reset asserted in cycle 8 of a conversion -> next edge shows state IDLE, bin_out=0, done=0, busy=0. A fresh conversion of 8'hFF then gives 8'hAA.
- Exhaustive sweep of all 256 Gray words with back-to-back requests -> bin_out matches the reference model each time, and done=1 exactly 2*WIDTH+1 cycles after the edge that samples start.
